// File: rtl/chip8_pkg.sv
// Shared Chip-8 definitions: stack command encoding and core-wide sizes.
package chip8_pkg;

    typedef enum logic [1:0] {
        STK_IDLE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10,
        STK_RSVD = 2'b11
    } stack_cmd_t;

    localparam int unsigned CHIP8_ADDR_W      = 16;
    localparam int unsigned CHIP8_STACK_DEPTH = 16;

endpackage

// File: rtl/chip8_stack.sv
// Chip-8 return-address LIFO: push on CALL, pop on RET; popped word is registered on outdata.
module chip8_stack
    import chip8_pkg::*;
#(
    parameter int unsigned WIDTH = CHIP8_ADDR_W,
    parameter int unsigned DEPTH = CHIP8_STACK_DEPTH
) (
    input  logic             cpu_clk,
    input  logic             reset_n,
    input  logic [1:0]       WE,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] outdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SpW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             push_en;
    logic [IdxW-1:0]  wr_idx, rd_idx;
    stack_cmd_t       cmd;

    assign cmd    = stack_cmd_t'(WE);
    assign full   = (sp_q == SpW'(DEPTH));
    assign empty  = (sp_q == '0);
    // sp is the next free slot; indices are only used when the guard flags allow it
    assign wr_idx = IdxW'(sp_q);
    assign rd_idx = IdxW'(sp_q - SpW'(1));

    always_comb begin
        sp_d    = sp_q;
        out_d   = out_q;
        push_en = 1'b0;
        unique case (cmd)
            STK_PUSH: begin
                if (!full) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SpW'(1);
                end
            end
            STK_POP: begin
                if (!empty) begin
                    out_d = mem_q[rd_idx];
                    sp_d  = sp_q - SpW'(1);
                end
            end
            STK_IDLE, STK_RSVD: ;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            sp_q  <= '0;
            out_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            out_q <= out_d;
            if (push_en) begin
                mem_q[wr_idx] <= writedata;
            end
        end
    end

    assign outdata = out_q;

endmodule

// File: tb/tb_chip8_stack.sv
// Bench for chip8_stack: directed vector table followed by random traffic against a queue model.
module tb_chip8_stack;
    import chip8_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned D = 16;

    logic         cpu_clk = 1'b0;
    logic         reset_n;
    logic [1:0]   WE;
    logic [W-1:0] writedata;
    logic [W-1:0] outdata;
    logic         full;
    logic         empty;

    int checks = 0;
    int errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    chip8_stack #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .cpu_clk  (cpu_clk),
        .reset_n  (reset_n),
        .WE       (WE),
        .writedata(writedata),
        .outdata  (outdata),
        .full     (full),
        .empty    (empty)
    );

    typedef struct {
        logic         rst;
        logic [1:0]   we;
        logic [W-1:0] wd;
        logic [W-1:0] out;
        logic         emp;
        logic         ful;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic [1:0] we, logic [W-1:0] wd,
                                logic [W-1:0] o, logic e, logic f);
        vec_t v;
        v.rst = rst; v.we = we; v.wd = wd; v.out = o; v.emp = e; v.ful = f;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [1:0] we, logic [W-1:0] wd);
        reset_n   = ~rst;
        WE        = we;
        writedata = wd;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check_all(string tag, logic [W-1:0] o, logic e, logic f);
        check({tag, ".outdata"}, outdata, o);
        check({tag, ".empty"}, W'(empty), W'(e));
        check({tag, ".full"}, W'(full), W'(f));
    endtask

    logic [W-1:0] mq[$];
    logic [W-1:0] mout;
    logic         rrst;
    logic [1:0]   rwe;
    logic [W-1:0] rwd;
    int           r;
    int           pushw;

    initial begin
        reset_n   = 1'b0;
        WE        = 2'b00;
        writedata = '0;

        // Reset held two cycles
        drive(1'b1, 2'b10, 16'hFFFF);
        drive(1'b1, 2'b00, 16'h0000);
        check_all("reset", 16'h0000, 1'b1, 1'b0);

        // Directed vectors: {rst, we, wd} -> {outdata, empty, full} after the edge
        add(0, 2'b10, 16'h0000, 16'h0000, 1, 0);
        add(0, 2'b01, 16'hF000, 16'h0000, 0, 0);
        add(0, 2'b01, 16'h0F00, 16'h0000, 0, 0);
        add(0, 2'b01, 16'h00F0, 16'h0000, 0, 0);
        add(0, 2'b01, 16'h000F, 16'h0000, 0, 0);
        add(0, 2'b10, 16'h0000, 16'h000F, 0, 0);
        add(0, 2'b01, 16'h000F, 16'h000F, 0, 0);
        add(0, 2'b10, 16'h0000, 16'h000F, 0, 0);
        add(0, 2'b10, 16'h0000, 16'h00F0, 0, 0);
        add(0, 2'b01, 16'h8888, 16'h00F0, 0, 0);
        add(0, 2'b10, 16'h0000, 16'h8888, 0, 0);
        add(0, 2'b10, 16'h0000, 16'h0F00, 0, 0);
        add(0, 2'b10, 16'h0000, 16'hF000, 1, 0);
        // Overflow
        for (int i = 1; i <= 16; i++) add(0, 2'b01, W'(i), 16'hF000, 0, (i == 16));
        add(0, 2'b01, 16'hDEAD, 16'hF000, 0, 1);
        add(0, 2'b10, 16'h0000, 16'h0010, 0, 0);
        for (int i = 15; i >= 1; i--) add(0, 2'b10, 16'h0000, W'(i), (i == 1), 0);
        // Underflow
        for (int i = 0; i < 3; i++) add(0, 2'b10, 16'h0000, 16'h0001, 1, 0);
        add(0, 2'b01, 16'h1234, 16'h0001, 0, 0);
        add(0, 2'b10, 16'h0000, 16'h1234, 1, 0);
        // Idle and reserved codes
        add(0, 2'b01, 16'hAAAA, 16'h1234, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 2'b00, 16'h5555, 16'h1234, 0, 0);
        for (int i = 0; i < 2; i++) add(0, 2'b11, 16'h5555, 16'h1234, 0, 0);
        add(0, 2'b10, 16'h0000, 16'hAAAA, 1, 0);
        // Reset in the middle of activity overrides a push
        add(0, 2'b01, 16'h1111, 16'hAAAA, 0, 0);
        add(0, 2'b01, 16'h2222, 16'hAAAA, 0, 0);
        add(1, 2'b01, 16'h3333, 16'h0000, 1, 0);
        add(0, 2'b10, 16'h0000, 16'h0000, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wd);
            check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].emp, vecs[i].ful);
        end

        // Random traffic against a queue model; stack is empty with outdata=0 here
        mout = '0;
        mq.delete();
        for (int n = 0; n < 1200; n++) begin
            pushw = ((n / 100) % 2 == 0) ? 75 : 20;
            rrst  = ($urandom_range(0, 149) == 0);
            r     = $urandom_range(0, 99);
            if (r < pushw)   rwe = 2'b01;
            else if (r < 90) rwe = 2'b10;
            else             rwe = (r < 95) ? 2'b00 : 2'b11;
            rwd = W'($urandom);

            if (rrst) begin
                mq.delete();
                mout = '0;
            end else if (rwe == 2'b01) begin
                if (mq.size() < D) mq.push_back(rwd);
            end else if (rwe == 2'b10) begin
                if (mq.size() > 0) mout = mq.pop_back();
            end

            drive(rrst, rwe, rwd);
            check_all($sformatf("rnd%0d", n), mout, (mq.size() == 0), (mq.size() == D));
        end

        reset_n = 1'b1;
        WE      = 2'b00;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
